// File: rtl/banked_lattice_ram.sv
`default_nettype none
// ============================================================================
// Module   : banked_lattice_ram
// Brief    : NUM_CHANNELS-bank simple dual-port RAM sharing one write and one
//            read address, with pipelined reads and a clear sequencer.
// Revision : 1.0  initial release
// ============================================================================
module banked_lattice_ram #(
    parameter int                    DATA_WIDTH    = 16,
    parameter int                    DEPTH         = 16,
    parameter int                    ADDRESS_WIDTH = 4,
    parameter int                    NUM_CHANNELS  = 9,
    parameter int                    READ_LATENCY  = 1,
    parameter int                    RDW_MODE      = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clear_start,
    output logic                                 busy,
    input  logic [NUM_CHANNELS-1:0]              write_en,
    input  logic [ADDRESS_WIDTH-1:0]             write_address,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   data_in,
    input  logic                                 read_en,
    input  logic [ADDRESS_WIDTH-1:0]             read_address,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   data_out,
    output logic                                 read_valid
);

    localparam int                       c_WORD_WIDTH = NUM_CHANNELS * DATA_WIDTH;
    localparam logic [ADDRESS_WIDTH:0]   c_DEPTH      = (ADDRESS_WIDTH + 1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] c_LAST_ADDR  = ADDRESS_WIDTH'(DEPTH - 1);

    generate
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $error("banked_lattice_ram: READ_LATENCY must be 1 or 2");
        end
        if ((64'd1 << ADDRESS_WIDTH) < 64'(DEPTH)) begin : g_bad_depth
            $error("banked_lattice_ram: ADDRESS_WIDTH too small for DEPTH");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                     r_state;
    logic [ADDRESS_WIDTH-1:0]   r_count;
    logic                       r_busy;
    logic                       w_idle;
    logic                       w_wr_in_range;
    logic                       w_rd_in_range;
    logic                       w_rd_fire;
    logic [NUM_CHANNELS-1:0]    w_wr_fire;
    logic [c_WORD_WIDTH-1:0]    w_rd_word;
    logic [c_WORD_WIDTH-1:0]    w_pipe_word;
    logic                       w_pipe_valid;
    logic [c_WORD_WIDTH-1:0]    r_data_out;
    logic                       r_read_valid;

    assign w_idle        = (r_state == ST_IDLE);
    assign w_wr_in_range = ({1'b0, write_address} < c_DEPTH);
    assign w_rd_in_range = ({1'b0, read_address} < c_DEPTH);
    assign w_rd_fire     = read_en && w_idle;
    assign w_wr_fire     = write_en & {NUM_CHANNELS{w_idle && w_wr_in_range}};

    // Clear sequencer: one address per cycle across all banks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
            r_count <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_count <= r_count + ADDRESS_WIDTH'(1);
                    if (r_count == c_LAST_ADDR) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_count <= '0;
                    end
                end
                ST_IDLE: begin
                    if (clear_start) begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                        r_count <= '0;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_busy  <= 1'b1;
                    r_count <= '0;
                end
            endcase
        end
    end

    generate
        for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_bank
            logic [DATA_WIDTH-1:0] r_mem [DEPTH];
            logic [DATA_WIDTH-1:0] w_word;

            always_ff @(posedge clk) begin
                if (!w_idle) begin
                    r_mem[r_count] <= CLEAR_VALUE;
                end else if (w_wr_fire[c]) begin
                    r_mem[write_address] <= data_in[c*DATA_WIDTH +: DATA_WIDTH];
                end
            end

            // Array read happens before the same-edge write lands, giving old data unless bypassed.
            always_comb begin
                w_word = '0;
                if (!w_rd_in_range) begin
                    w_word = '0;
                end else if (RDW_MODE == 1 && w_wr_fire[c] && write_address == read_address) begin
                    w_word = data_in[c*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    w_word = r_mem[read_address];
                end
            end

            assign w_rd_word[c*DATA_WIDTH +: DATA_WIDTH] = w_word;
        end

        if (READ_LATENCY == 2) begin : g_lat2
            logic [c_WORD_WIDTH-1:0] r_s1_word;
            logic                    r_s1_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s1_word  <= '0;
                    r_s1_valid <= 1'b0;
                end else begin
                    r_s1_valid <= w_rd_fire;
                    if (w_rd_fire) begin
                        r_s1_word <= w_rd_word;
                    end
                end
            end

            assign w_pipe_word  = r_s1_word;
            assign w_pipe_valid = r_s1_valid;
        end else begin : g_lat1
            assign w_pipe_word  = w_rd_word;
            assign w_pipe_valid = w_rd_fire;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out   <= '0;
            r_read_valid <= 1'b0;
        end else begin
            r_read_valid <= w_pipe_valid;
            if (w_pipe_valid) begin
                r_data_out <= w_pipe_word;
            end
        end
    end

    assign busy       = r_busy;
    assign data_out   = r_data_out;
    assign read_valid = r_read_valid;

endmodule
`default_nettype wire
